// File: rtl/attention_softmax_norm.sv
// Softmax normalisation stage: sums each row of E, takes the reciprocal and scales
// the row into an internal P array. FP32 add/div/mul go to shared external units.
module attention_softmax_norm #(
  parameter  int unsigned T      = 8,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned T_W    = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [T-1:0]      row_zero,
  output logic              e_re,
  output logic [T_W-1:0]    e_tq,
  output logic [T_W-1:0]    e_tk,
  input  logic [DATA_W-1:0] e_rdata,
  input  logic              e_rvalid,
  output logic              add_start,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic              add_done,
  input  logic [31:0]       add_z,
  output logic              div_start,
  output logic [31:0]       div_a,
  output logic [31:0]       div_b,
  input  logic              div_done,
  input  logic [31:0]       div_z,
  output logic              mul_start,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic              mul_done,
  input  logic [31:0]       mul_z,
  input  logic              p_re,
  input  logic [T_W-1:0]    p_tq,
  input  logic [T_W-1:0]    p_tk,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid
);

  localparam logic [31:0]    FP_ONE = 32'h3F80_0000;
  localparam logic [T_W-1:0] LAST   = T_W'(T - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SUM_REQ, S_SUM_WAIT, S_ADD_WAIT, S_DIV_WAIT,
    S_MUL_ISSUE, S_MUL_WAIT, S_NEXT_ROW, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [T_W-1:0]      r_q, r_d, c_q, c_d;
  logic [DATA_W-1:0]   acc_q, acc_d, recip_q, recip_d;
  logic [T-1:0]        row_zero_q, row_zero_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                e_re_q, e_re_d;
  logic [T_W-1:0]      e_tq_q, e_tq_d, e_tk_q, e_tk_d;
  logic                add_start_q, add_start_d, div_start_q, div_start_d;
  logic                mul_start_q, mul_start_d;
  logic [31:0]         add_a_q, add_a_d, add_b_q, add_b_d;
  logic [31:0]         div_a_q, div_a_d, div_b_q, div_b_d;
  logic [31:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                p_rvalid_q;
  logic [DATA_W-1:0]   p_rdata_q;

  logic [DATA_W-1:0]   rowbuf_q [T];
  logic [DATA_W-1:0]   p_q      [T][T];

  logic                rowbuf_we, p_we, p_row_clr, sum_fin, last_col;
  logic [DATA_W-1:0]   p_wdata, sum_val;

  assign last_col = (c_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      acc_q       <= '0;
      recip_q     <= '0;
      row_zero_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      e_re_q      <= 1'b0;
      e_tq_q      <= '0;
      e_tk_q      <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      div_start_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      recip_q     <= recip_d;
      row_zero_q  <= row_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      e_re_q      <= e_re_d;
      e_tq_q      <= e_tq_d;
      e_tk_q      <= e_tk_d;
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      div_start_q <= div_start_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    acc_d       = acc_q;
    recip_d     = recip_q;
    row_zero_d  = row_zero_q;
    e_re_d      = 1'b0;
    e_tq_d      = e_tq_q;
    e_tk_d      = e_tk_q;
    add_start_d = 1'b0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    div_start_d = 1'b0;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rowbuf_we   = 1'b0;
    p_we        = 1'b0;
    p_row_clr   = 1'b0;
    p_wdata     = '0;
    sum_fin     = 1'b0;
    sum_val     = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d        = '0;
          c_d        = '0;
          row_zero_d = '0;
          state_d    = S_SUM_REQ;
        end
      end
      S_SUM_REQ: state_d = S_SUM_WAIT;
      S_SUM_WAIT: begin
        if (e_rvalid) begin
          rowbuf_we = 1'b1;
          if (c_q == '0) begin
            acc_d = e_rdata;
            if (last_col) begin
              sum_fin = 1'b1;
              sum_val = e_rdata;
            end else begin
              c_d     = c_q + T_W'(1);
              state_d = S_SUM_REQ;
            end
          end else begin
            add_start_d = 1'b1;
            add_a_d     = acc_q;
            add_b_d     = e_rdata;
            state_d     = S_ADD_WAIT;
          end
        end
      end
      S_ADD_WAIT: begin
        if (add_done) begin
          acc_d = add_z;
          if (last_col) begin
            sum_fin = 1'b1;
            sum_val = add_z;
          end else begin
            c_d     = c_q + T_W'(1);
            state_d = S_SUM_REQ;
          end
        end
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          recip_d = div_z;
          c_d     = '0;
          state_d = S_MUL_ISSUE;
        end
      end
      S_MUL_ISSUE: begin
        // Zero elements (masked positions) bypass the multiplier and write +0.
        if (rowbuf_q[c_q][30:0] == '0) begin
          p_we    = 1'b1;
          state_d = last_col ? S_NEXT_ROW : S_MUL_ISSUE;
          if (!last_col) c_d = c_q + T_W'(1);
        end else begin
          mul_start_d = 1'b1;
          mul_a_d     = rowbuf_q[c_q];
          mul_b_d     = recip_q;
          state_d     = S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          p_we    = 1'b1;
          p_wdata = mul_z;
          state_d = last_col ? S_NEXT_ROW : S_MUL_ISSUE;
          if (!last_col) c_d = c_q + T_W'(1);
        end
      end
      S_NEXT_ROW: begin
        if (r_q == LAST) begin
          state_d = S_DONE;
        end else begin
          r_d     = r_q + T_W'(1);
          c_d     = '0;
          state_d = S_SUM_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Row sum complete: a +/-0 sum marks the row and zero-fills it without dividing.
    if (sum_fin) begin
      if (sum_val[30:0] == '0) begin
        row_zero_d[r_q] = 1'b1;
        p_row_clr       = 1'b1;
        state_d         = S_NEXT_ROW;
      end else begin
        div_start_d = 1'b1;
        div_a_d     = FP_ONE;
        div_b_d     = sum_val;
        state_d     = S_DIV_WAIT;
      end
    end

    // The E read is launched on entry so it is visible during the SUM_REQ cycle.
    if (state_d == S_SUM_REQ) begin
      e_re_d = 1'b1;
      e_tq_d = r_d;
      e_tk_d = c_d;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(T); i++) rowbuf_q[i] <= '0;
    end else if (rowbuf_we) begin
      rowbuf_q[c_q] <= e_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(T); i++)
        for (int j = 0; j < int'(T); j++) p_q[i][j] <= '0;
    end else if (p_row_clr) begin
      for (int j = 0; j < int'(T); j++) p_q[r_q][j] <= '0;
    end else if (p_we) begin
      p_q[r_q][c_q] <= p_wdata;
    end
  end

  // P read port samples the array before any same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rvalid_q <= 1'b0;
      p_rdata_q  <= '0;
    end else begin
      p_rvalid_q <= p_re;
      if (p_re) p_rdata_q <= p_q[p_tq][p_tk];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign row_zero  = row_zero_q;
  assign e_re      = e_re_q;
  assign e_tq      = e_tq_q;
  assign e_tk      = e_tk_q;
  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign p_rvalid  = p_rvalid_q;
  assign p_rdata   = p_rdata_q;

endmodule
